// File: rtl/ws2812b_chain_tx.sv
`timescale 1ns/1ps
// ws2812b_chain_tx
// Serialises a chain of NUM_LEDS WS2812B pixels. On start it pulls one 24-bit
// GRB word per LED from a valid/ready stream, sends each word MSB-first as
// WS2812B high/low pulses and closes every frame with a low latch interval.
// A stream stall longer than UNDERRUN_MAX cycles aborts the frame into the
// latch so downstream LEDs still latch what they already received.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   start      frame request, only looked at while idle
//   busy       frame in progress
//   done       one-cycle pulse at the end of every frame (aborted ones too)
//   underrun   one-cycle pulse when a frame is aborted on a stream stall
//   pix_data   {green, red, blue}, bit 23 sent first
//   pix_valid  pix_data is valid
//   pix_ready  asserted while waiting for the next pixel word
//   led_out    WS2812B data line
module ws2812b_chain_tx #(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned T0H          = 11,
    parameter int unsigned T1H          = 22,
    parameter int unsigned TBIT         = 34,
    parameter int unsigned TRESET       = 2160,
    parameter int unsigned UNDERRUN_MAX = 135
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        led_out
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 5;
    localparam int unsigned LED_W = $clog2(NUM_LEDS + 1);

    // Cycle-counter reload values, one per state entry flavour
    localparam logic [CNT_W-1:0] HIGH0_C = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] HIGH1_C = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] LOW0_C  = CNT_W'(TBIT - T0H);
    localparam logic [CNT_W-1:0] LOW1_C  = CNT_W'(TBIT - T1H);
    localparam logic [CNT_W-1:0] LATCH_C = CNT_W'(TRESET);
    localparam logic [CNT_W-1:0] WAIT_C  = CNT_W'(UNDERRUN_MAX);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    localparam logic [BIT_W-1:0] MSB_IDX  = BIT_W'(23);
    localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BIT_HIGH,
        S_BIT_LOW,
        S_LATCH
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [BIT_W-1:0] bit_idx_q,  bit_idx_d;
    logic [LED_W-1:0] led_cnt_q,  led_cnt_d;
    logic [23:0]      shreg_q,    shreg_d;
    logic             led_out_q,  led_out_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             underrun_q, underrun_d;

    // Next-state, counters and registered-output next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        led_cnt_d  = led_cnt_q;
        shreg_d    = shreg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    cnt_d     = WAIT_C;
                    led_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end

            S_FETCH: begin
                // A handshake on the last allowed wait cycle still wins
                if (pix_valid) begin
                    shreg_d   = pix_data;
                    bit_idx_d = MSB_IDX;
                    state_d   = S_BIT_HIGH;
                    cnt_d     = pix_data[23] ? HIGH1_C : HIGH0_C;
                end else if (cnt_q <= ONE_C) begin
                    underrun_d = 1'b1;
                    state_d    = S_LATCH;
                    cnt_d      = LATCH_C;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            S_BIT_HIGH: begin
                if (cnt_q <= ONE_C) begin
                    state_d = S_BIT_LOW;
                    cnt_d   = shreg_q[23] ? LOW1_C : LOW0_C;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            S_BIT_LOW: begin
                if (cnt_q <= ONE_C) begin
                    shreg_d = {shreg_q[22:0], 1'b0};
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - BIT_W'(1);
                        state_d   = S_BIT_HIGH;
                        // shreg_q[22] becomes the MSB after this shift
                        cnt_d     = shreg_q[22] ? HIGH1_C : HIGH0_C;
                    end else begin
                        led_cnt_d = led_cnt_q + LED_W'(1);
                        if (led_cnt_q == LAST_LED) begin
                            state_d = S_LATCH;
                            cnt_d   = LATCH_C;
                        end else begin
                            state_d = S_FETCH;
                            cnt_d   = WAIT_C;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            S_LATCH: begin
                if (cnt_q <= ONE_C) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Line follows the next state so it is high exactly while in BIT_HIGH
        led_out_d = (state_d == S_BIT_HIGH);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            led_cnt_q  <= '0;
            shreg_q    <= '0;
            led_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            led_cnt_q  <= led_cnt_d;
            shreg_q    <= shreg_d;
            led_out_q  <= led_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign pix_ready = (state_q == S_FETCH);
    assign led_out   = led_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_ws2812b_chain_tx.sv
`timescale 1ns/1ps
// Bench for ws2812b_chain_tx: a 1-LED and a 3-LED instance share the stimulus,
// a select picks which one is driven and observed. The LED line is decoded
// back into words and compared against the words handed to the stream.
module tb_ws2812b_chain_tx;

    localparam int T0H    = 11;
    localparam int T1H    = 22;
    localparam int TBIT   = 34;
    localparam int TRESET = 2160;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        sel;          // 0: 1-LED instance, 1: 3-LED instance

    logic d1_busy, d1_done, d1_und, d1_ready, d1_led;
    logic d3_busy, d3_done, d3_und, d3_ready, d3_led;
    logic obs_busy, obs_done, obs_und, obs_ready, obs_led;

    always #5 clk = ~clk;

    ws2812b_chain_tx #(.NUM_LEDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start & ~sel),
        .busy(d1_busy), .done(d1_done), .underrun(d1_und),
        .pix_data(pix_data), .pix_valid(pix_valid & ~sel),
        .pix_ready(d1_ready), .led_out(d1_led)
    );

    ws2812b_chain_tx #(.NUM_LEDS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start & sel),
        .busy(d3_busy), .done(d3_done), .underrun(d3_und),
        .pix_data(pix_data), .pix_valid(pix_valid & sel),
        .pix_ready(d3_ready), .led_out(d3_led)
    );

    assign obs_busy  = sel ? d3_busy  : d1_busy;
    assign obs_done  = sel ? d3_done  : d1_done;
    assign obs_und   = sel ? d3_und   : d1_und;
    assign obs_ready = sel ? d3_ready : d1_ready;
    assign obs_led   = sel ? d3_led   : d1_led;

    typedef struct {
        logic            sel;
        logic [2:0][23:0] w;
        logic [2:0][7:0]  stall;     // cycles valid is held low in FETCH before word i
        logic            mid_start;
        int              exp_hs;
        logic            exp_und;
        int              exp_len;    // cycles from start edge to done, inclusive
    } vec_t;

    vec_t vec [6];

    int tests = 0;
    int fails = 0;

    int cyc, start_cyc, done_cyc, und_cyc;
    int hs_seen, done_cnt, und_cnt, ready_bad, done_busy_bad;
    logic [23:0] exp_q [$];
    int ext_q [$];

    // line decoder state
    logic        mon_en;
    logic        prev_led, have_bit;
    int          run, last_h, bits, timing_err;
    logic [23:0] word;

    function automatic vec_t mk(input logic s, input logic [23:0] w0, input logic [23:0] w1,
                                input logic [23:0] w2, input int s0, input int s1, input int s2,
                                input logic mid, input int hs, input logic und, input int len);
        vec_t r;
        r.sel       = s;
        r.w[0]      = w0;
        r.w[1]      = w1;
        r.w[2]      = w2;
        r.stall[0]  = 8'(s0);
        r.stall[1]  = 8'(s1);
        r.stall[2]  = 8'(s2);
        r.mid_start = mid;
        r.exp_hs    = hs;
        r.exp_und   = und;
        r.exp_len   = len;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic decode();
        logic b;
        if (obs_led && !prev_led) begin
            if (have_bit) begin
                if (bits != 0) begin
                    if (run != TBIT - last_h) timing_err++;
                end else begin
                    ext_q.push_back(run - (TBIT - last_h));
                end
            end
            run = 1;
        end else if (!obs_led && prev_led) begin
            last_h   = run;
            have_bit = 1'b1;
            b = 1'b0;
            if (run == T1H) b = 1'b1;
            else if (run != T0H) timing_err++;
            word = {word[22:0], b};
            bits++;
            if (bits == 24) begin
                bits = 0;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word: got 0x%06h, no word expected", word);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    if (word !== e) begin
                        fails++;
                        $display("FAIL word: got 0x%06h, expected 0x%06h", word, e);
                    end
                end
            end
            run = 1;
        end else begin
            run++;
        end
        prev_led = obs_led;
    endtask

    // One clock: count the handshake the edge will take, then sample after it
    task automatic step();
        if (pix_valid && obs_ready) hs_seen++;
        @(posedge clk);
        #1;
        cyc++;
        if (obs_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (obs_busy) done_busy_bad++;
        end
        if (obs_und) begin
            und_cnt++;
            und_cyc = cyc;
        end
        if (obs_ready && (obs_led || !obs_busy)) ready_bad++;
        if (mon_en) decode();
    endtask

    task automatic begin_frame(input vec_t v);
        sel = v.sel;
        exp_q.delete();
        ext_q.delete();
        mon_en = 1'b1;
        prev_led = 1'b0;
        have_bit = 1'b0;
        run = 0; last_h = 0; bits = 0; timing_err = 0; word = '0;
        hs_seen = 0; done_cnt = 0; und_cnt = 0; ready_bad = 0; done_busy_bad = 0;
        done_cyc = 0; und_cyc = 0;
    endtask

    task automatic feed(input vec_t v);
        int nw;
        nw = v.sel ? 3 : 1;
        for (int i = 0; i < nw; i++) begin
            int g;
            int s;
            s = int'(v.stall[i]);
            if (v.mid_start && i == 1) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
            if (s == 0) begin
                pix_data  = v.w[i];
                pix_valid = 1'b1;
            end else begin
                pix_data  = ~v.w[i];
                pix_valid = 1'b0;
            end
            g = 0;
            while (!obs_ready && obs_busy && g < 2000) begin
                step();
                g++;
            end
            for (int k = 0; k < s; k++) step();
            pix_data  = v.w[i];
            pix_valid = 1'b1;
            // Stalled out: the word stays offered for the rest of the frame
            if (!obs_ready) break;
            exp_q.push_back(v.w[i]);
            step();
            pix_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done_cnt == 0 && g < 20000) begin
            step();
            g++;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL wait_done: no done within %0d cycles", g);
        end
    endtask

    task automatic check_frame(input vec_t v);
        chk("handshakes", hs_seen, v.exp_hs);
        chk("words_left", exp_q.size(), 0);
        chk("partial_bits", bits, 0);
        chk("bit_timing_errors", timing_err, 0);
        chk("gap_count", ext_q.size(), v.exp_hs - 1);
        if (ext_q.size() == v.exp_hs - 1) begin
            // a FETCH with no stall still adds one low cycle
            for (int j = 0; j < ext_q.size(); j++)
                chk("gap_low_extension", ext_q[j], int'(v.stall[j + 1]) + 1);
        end
        chk("frame_len", done_cyc - start_cyc + 1, v.exp_len);
        chk("underrun_pulses", und_cnt, int'(v.exp_und));
        if (v.exp_und) chk("latch_after_underrun", done_cyc - und_cyc, TRESET);
        chk("ready_outside_fetch", ready_bad, 0);
        chk("done_while_busy", done_busy_bad, 0);
    endtask

    task automatic run_frame(input vec_t v);
        begin_frame(v);
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        chk("busy_cycle1", int'(obs_busy), 1);
        chk("ready_cycle1", int'(obs_ready), 1);
        feed(v);
        wait_done();
        pix_valid = 1'b0;
        check_frame(v);
        repeat (20) step();
        chk("no_second_frame", int'(obs_busy), 0);
        chk("done_pulses", done_cnt, 1);
    endtask

    initial begin
        int g;
        int a_done;
        vec_t vb;

        // sel, w0, w1, w2, stall0..2, mid start, handshakes, underrun, frame length
        vec[0] = mk(1'b0, 24'h800001, 24'h0,      24'h0,      0, 0,   0, 1'b0, 1, 1'b0, 2978);
        vec[1] = mk(1'b1, 24'hFF0000, 24'h00FF00, 24'h0000FF, 0, 5,   0, 1'b0, 3, 1'b0, 4617);
        vec[2] = mk(1'b1, 24'hA5C33C, 24'h123456, 24'h0F0F0F, 0, 135, 0, 1'b0, 1, 1'b1, 3113);
        vec[3] = mk(1'b1, 24'h000000, 24'hFFFFFF, 24'h800001, 0, 134, 0, 1'b0, 3, 1'b0, 4746);
        vec[4] = mk(1'b1, 24'h000000, 24'h000000, 24'h000000, 0, 0,   0, 1'b1, 3, 1'b0, 4612);
        vec[5] = mk(1'b1, 24'h5A5A5A, 24'hC0FFEE, 24'h010203, 0, 0,   3, 1'b0, 3, 1'b0, 4615);

        cyc = 0;
        rst = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        sel = 1'b0;
        begin_frame(vec[0]);
        mon_en = 1'b0;

        // reset state of both instances
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst_led_out", int'(obs_led), 0);
            chk("rst_busy", int'(obs_busy), 0);
            chk("rst_done", int'(obs_done), 0);
            chk("rst_underrun", int'(obs_und), 0);
            chk("rst_pix_ready", int'(obs_ready), 0);
        end
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_frame(vec[i]);

        // reset while the first LED's first bit is high
        begin_frame(vec[1]);
        mon_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        pix_data  = 24'hFFFFFF;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        g = 0;
        while (!obs_led && g < 100) begin
            step();
            g++;
        end
        repeat (5) step();
        chk("pre_rst_led_high", int'(obs_led), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_led_out", int'(obs_led), 0);
        chk("midrst_busy", int'(obs_busy), 0);
        chk("midrst_done", int'(obs_done), 0);
        chk("midrst_underrun", int'(obs_und), 0);
        chk("midrst_pix_ready", int'(obs_ready), 0);
        repeat (3) step();
        run_frame(vec[1]);

        // start held high across done: next frame follows with no gap
        begin_frame(vec[5]);
        start = 1'b1;
        step();
        start_cyc = cyc;
        feed(vec[5]);
        wait_done();
        check_frame(vec[5]);
        a_done = done_cyc;
        vb = vec[1];
        begin_frame(vb);
        step();
        start = 1'b0;
        start_cyc = cyc;
        chk("b2b_start_gap", start_cyc - a_done, 1);
        chk("b2b_ready", int'(obs_ready), 1);
        chk("b2b_busy", int'(obs_busy), 1);
        feed(vb);
        wait_done();
        pix_valid = 1'b0;
        check_frame(vb);
        repeat (5) step();
        chk("b2b_idle", int'(obs_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
